// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state enum, stage record and tag sizing for the pipeline tag controller
package pipe_ctrl_pkg;

    localparam int NUM_TAGS = 72;
    localparam int TAG_W    = 7;
    localparam int SCNT_W   = 3;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [SCNT_W-1:0] scnt;
    } stage_tag_t;

    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return (t == TAG_W'(NUM_TAGS - 1)) ? '0 : t + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_tag_stage.sv
// pipe_tag_stage: one pipeline stage record with hold (and saturating stall count), bubble and flush
module pipe_tag_stage
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  stage_tag_t d_i,
    input  logic       hold_i,
    input  logic       bubble_i,
    input  logic       flush_i,
    input  logic       inc_i,
    output stage_tag_t q_o
);

    stage_tag_t q_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= '0;
        else if (flush_i || bubble_i) q_q <= '0;
        else if (hold_i) q_q.scnt <= (inc_i && q_q.scnt != '1) ? q_q.scnt + 1'b1 : q_q.scnt;
        else q_q <= d_i;

    assign q_o = q_q;

endmodule

// File: rtl/pipeline_tag_controller.sv
// pipeline_tag_controller: 5-stage sequencing and tag tracking; PIPE_PERF_CNT_EN adds perf counters
module pipeline_tag_controller
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall_req,
    input  logic              flush_req,
    input  logic              halt_dec,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              if_valid,
    output logic              id_valid,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  if_tag,
    output logic [TAG_W-1:0]  id_tag,
    output logic [TAG_W-1:0]  ex_tag,
    output logic [TAG_W-1:0]  mem_tag,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              retire,
    output logic [TAG_W-1:0]  retire_tag,
    output logic [SCNT_W-1:0] retire_stalls,
    output logic              done,
    output logic [1:0]        state,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ret_cnt,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_cnt_q, halt_tag_q;
    stage_tag_t       fetch, if_s, id_s, ex_s, mem_s, wb_s;
    logic             run, drain, stall_acc, flush_acc, halt_acc;

    assign run       = state_q == RUN;
    assign drain     = state_q == DRAIN;
    assign stall_acc = run && stall_req && id_s.valid;
    assign flush_acc = run && flush_req && !stall_req && id_s.valid;
    assign halt_acc  = run && halt_dec && !stall_req && id_s.valid;

    // Halt freezes IF so the instruction behind HLT is the one DRAIN kills
    assign pc_we       = run && !stall_acc && !halt_acc;
    assign ifid_we     = pc_we;
    assign ifid_flush  = flush_acc || halt_acc || drain;
    assign idex_bubble = stall_acc;
    assign fetch       = {1'b1, tag_cnt_q, SCNT_W'(0)};

    always_comb
        state_d = (state_q == IDLE && start) ? RUN :
                  halt_acc ? DRAIN :
                  (drain && wb_s.valid && wb_s.tag == halt_tag_q) ? DONE : state_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            tag_cnt_q  <= '0;
            halt_tag_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_we) tag_cnt_q <= next_tag(tag_cnt_q);
            if (halt_acc) halt_tag_q <= id_s.tag;
        end

    pipe_tag_stage u_if  (.clk, .rst_n, .d_i(fetch), .hold_i(!pc_we),   .bubble_i(1'b0),        .flush_i(drain),      .inc_i(1'b0),      .q_o(if_s));
    pipe_tag_stage u_id  (.clk, .rst_n, .d_i(if_s),  .hold_i(!ifid_we), .bubble_i(1'b0),        .flush_i(ifid_flush), .inc_i(stall_acc), .q_o(id_s));
    pipe_tag_stage u_ex  (.clk, .rst_n, .d_i(id_s),  .hold_i(1'b0),     .bubble_i(idex_bubble), .flush_i(1'b0),       .inc_i(1'b0),      .q_o(ex_s));
    pipe_tag_stage u_mem (.clk, .rst_n, .d_i(ex_s),  .hold_i(1'b0),     .bubble_i(1'b0),        .flush_i(1'b0),       .inc_i(1'b0),      .q_o(mem_s));
    pipe_tag_stage u_wb  (.clk, .rst_n, .d_i(mem_s), .hold_i(1'b0),     .bubble_i(1'b0),        .flush_i(1'b0),       .inc_i(1'b0),      .q_o(wb_s));

    assign {if_valid, if_tag}   = {if_s.valid, if_s.tag};
    assign {id_valid, id_tag}   = {id_s.valid, id_s.tag};
    assign {ex_valid, ex_tag}   = {ex_s.valid, ex_s.tag};
    assign {mem_valid, mem_tag} = {mem_s.valid, mem_s.tag};
    assign {wb_valid, wb_tag}   = {wb_s.valid, wb_s.tag};
    assign retire        = wb_s.valid;
    assign retire_tag    = wb_s.tag;
    assign retire_stalls = wb_s.scnt;
    assign done          = state_q == DONE;
    assign state         = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cyc_q, ret_q, stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cyc_q   <= '0;
            ret_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (run || drain) cyc_q <= cyc_q + 32'd1;
            if (wb_s.valid) ret_q <= ret_q + 32'd1;
            if (stall_acc) stall_q <= stall_q + 32'd1;
            if (flush_acc) flush_q <= flush_q + 32'd1;
        end

    assign {cyc_cnt, ret_cnt, stall_cnt, flush_cnt} = {cyc_q, ret_q, stall_q, flush_q};
`else
    assign {cyc_cnt, ret_cnt, stall_cnt, flush_cnt} = '0;
`endif

endmodule

// File: tb/tb_pipeline_tag_controller.sv
// tb_pipeline_tag_controller: directed scenarios for pipeline_tag_controller with hand-derived expectations
module tb_pipeline_tag_controller;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall_req = 1'b0, flush_req = 1'b0, halt_dec = 1'b0;
    logic pc_we, ifid_we, ifid_flush, idex_bubble;
    logic if_valid, id_valid, ex_valid, mem_valid, wb_valid;
    logic [TAG_W-1:0] if_tag, id_tag, ex_tag, mem_tag, wb_tag, retire_tag;
    logic retire, done;
    logic [SCNT_W-1:0] retire_stalls;
    logic [1:0] state;
    logic [31:0] cyc_cnt, ret_cnt, stall_cnt, flush_cnt;
    int total = 0, bad = 0;

    pipeline_tag_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall_req(stall_req), .flush_req(flush_req), .halt_dec(halt_dec),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .if_valid(if_valid), .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .if_tag(if_tag), .id_tag(id_tag), .ex_tag(ex_tag), .mem_tag(mem_tag), .wb_tag(wb_tag),
        .retire(retire), .retire_tag(retire_tag), .retire_stalls(retire_stalls), .done(done), .state(state),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #3;
        total++; if (state !== 2'd0 || pc_we !== 1'b0 || ifid_we !== 1'b0 || ifid_flush !== 1'b0 || idex_bubble !== 1'b0)
            begin bad++; $display("FAIL reset_ctrl state=%0d pc_we=%b ifid_we=%b flush=%b bubble=%b exp all 0", state, pc_we, ifid_we, ifid_flush, idex_bubble); end
        #9 rst_n = 1'b1;
        #1;
        total++; if ({if_valid, id_valid, ex_valid, mem_valid, wb_valid, retire, done} !== 7'd0 || {if_tag, id_tag, ex_tag, mem_tag, wb_tag} !== '0)
            begin bad++; $display("FAIL reset_stages valids=%b%b%b%b%b retire=%b done=%b exp 0", if_valid, id_valid, ex_valid, mem_valid, wb_valid, retire, done); end
        total++; if ({cyc_cnt, ret_cnt, stall_cnt, flush_cnt} !== '0)
            begin bad++; $display("FAIL reset_perf cyc=%0d ret=%0d stall=%0d flush=%0d exp 0", cyc_cnt, ret_cnt, stall_cnt, flush_cnt); end
        tick();
        total++; if (state !== 2'd0 || pc_we !== 1'b0 || if_valid !== 1'b0)
            begin bad++; $display("FAIL idle_hold state=%0d pc_we=%b if_valid=%b exp 0/0/0", state, pc_we, if_valid); end
    endtask

    task automatic test_free_run;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        total++; if (state !== 2'd1 || pc_we !== 1'b1 || ifid_we !== 1'b1 || ifid_flush !== 1'b0)
            begin bad++; $display("FAIL run_ctrl state=%0d pc_we=%b ifid_we=%b flush=%b exp 1/1/1/0", state, pc_we, ifid_we, ifid_flush); end
        for (int k = 0; k < 6; k++) begin
            tick();
            total++; if (if_valid !== 1'b1 || if_tag !== TAG_W'(k))
                begin bad++; $display("FAIL fetch_tag k=%0d got=%0d/%b exp=%0d/1", k, if_tag, if_valid, k); end
            total++; if (retire !== (k >= 4) || (k >= 4 && (retire_tag !== TAG_W'(k - 4) || retire_stalls !== 3'd0)))
                begin bad++; $display("FAIL first_retire k=%0d retire=%b tag=%0d st=%0d exp retire=%b tag=%0d st=0", k, retire, retire_tag, retire_stalls, k >= 4, k - 4); end
        end
    endtask

    // Pipeline here: IF=5 ID=4 EX=3 MEM=2 WB=1
    task automatic test_stall;
        stall_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (pc_we !== 1'b0 || ifid_we !== 1'b0 || idex_bubble !== 1'b1)
                begin bad++; $display("FAIL stall_ctrl c=%0d pc_we=%b ifid_we=%b bubble=%b exp 0/0/1", c, pc_we, ifid_we, idex_bubble); end
            tick();
            total++; if (ex_valid !== 1'b0 || if_tag !== 7'd5 || id_tag !== 7'd4 || retire_tag !== TAG_W'(2 + c))
                begin bad++; $display("FAIL stall_hold c=%0d ex_v=%b if=%0d id=%0d wb=%0d exp 0/5/4/%0d", c, ex_valid, if_tag, id_tag, retire_tag, 2 + c); end
        end
        stall_req = 1'b0;
        tick();
        total++; if (retire !== 1'b0 || ex_tag !== 7'd4 || if_tag !== 7'd6)
            begin bad++; $display("FAIL stall_release retire=%b ex=%0d if=%0d exp 0/4/6", retire, ex_tag, if_tag); end
        tick();
        total++; if (retire !== 1'b0)
            begin bad++; $display("FAIL stall_gap retire=%b exp 0", retire); end
        tick();
        total++; if (retire !== 1'b1 || retire_tag !== 7'd4 || retire_stalls !== 3'd2)
            begin bad++; $display("FAIL stall_retire retire=%b tag=%0d st=%0d exp 1/4/2", retire, retire_tag, retire_stalls); end
    endtask

    // Pipeline here: IF=8 ID=7 EX=6 MEM=5 WB=4
    task automatic test_flush;
        total++; if (id_tag !== 7'd7 || if_tag !== 7'd8)
            begin bad++; $display("FAIL flush_pre id=%0d if=%0d exp 7/8", id_tag, if_tag); end
        flush_req = 1'b1;
        #1;
        total++; if (pc_we !== 1'b1 || ifid_flush !== 1'b1 || idex_bubble !== 1'b0)
            begin bad++; $display("FAIL flush_ctrl pc_we=%b flush=%b bubble=%b exp 1/1/0", pc_we, ifid_flush, idex_bubble); end
        tick();
        flush_req = 1'b0;
        total++; if (id_valid !== 1'b0 || if_tag !== 7'd9 || ex_tag !== 7'd7)
            begin bad++; $display("FAIL flush_kill id_v=%b if=%0d ex=%0d exp 0/9/7", id_valid, if_tag, ex_tag); end
        tick();
        tick();
        total++; if (retire !== 1'b1 || retire_tag !== 7'd7)
            begin bad++; $display("FAIL flush_before retire=%b tag=%0d exp 1/7", retire, retire_tag); end
        tick();
        total++; if (retire !== 1'b0)
            begin bad++; $display("FAIL flush_hole retire=%b tag=%0d exp 0", retire, retire_tag); end
        tick();
        total++; if (retire !== 1'b1 || retire_tag !== 7'd9)
            begin bad++; $display("FAIL flush_after retire=%b tag=%0d exp 1/9", retire, retire_tag); end
    endtask

    // Pipeline here: IF=13 ID=12 EX=11 MEM=10 WB=9
    task automatic test_stall_flush;
        stall_req = 1'b1;
        flush_req = 1'b1;
        #1;
        total++; if (pc_we !== 1'b0 || ifid_flush !== 1'b0 || idex_bubble !== 1'b1)
            begin bad++; $display("FAIL both_ctrl pc_we=%b flush=%b bubble=%b exp 0/0/1", pc_we, ifid_flush, idex_bubble); end
        tick();
        stall_req = 1'b0;
        total++; if (if_valid !== 1'b1 || if_tag !== 7'd13 || id_tag !== 7'd12 || id_valid !== 1'b1)
            begin bad++; $display("FAIL both_hold if=%0d/%b id=%0d/%b exp 13/1 12/1", if_tag, if_valid, id_tag, id_valid); end
        #1;
        total++; if (pc_we !== 1'b1 || ifid_flush !== 1'b1)
            begin bad++; $display("FAIL both_late_flush pc_we=%b flush=%b exp 1/1", pc_we, ifid_flush); end
        tick();
        flush_req = 1'b0;
        total++; if (id_valid !== 1'b0 || if_tag !== 7'd14 || ex_tag !== 7'd12)
            begin bad++; $display("FAIL both_kill id_v=%b if=%0d ex=%0d exp 0/14/12", id_valid, if_tag, ex_tag); end
        tick();
        tick();
        total++; if (retire !== 1'b1 || retire_tag !== 7'd12 || retire_stalls !== 3'd1)
            begin bad++; $display("FAIL both_retire tag=%0d st=%0d exp 12/1", retire_tag, retire_stalls); end
        tick();
        total++; if (retire !== 1'b0)
            begin bad++; $display("FAIL both_hole retire=%b tag=%0d exp 0", retire, retire_tag); end
        tick();
        total++; if (retire !== 1'b1 || retire_tag !== 7'd14)
            begin bad++; $display("FAIL both_next retire=%b tag=%0d exp 1/14", retire, retire_tag); end
    endtask

    // Pipeline here: IF=18 ID=17 EX=16 MEM=15 WB=14
    task automatic test_halt;
        halt_dec = 1'b1;
        #1;
        total++; if (pc_we !== 1'b0 || ifid_flush !== 1'b1)
            begin bad++; $display("FAIL halt_ctrl pc_we=%b flush=%b exp 0/1", pc_we, ifid_flush); end
        tick();
        halt_dec = 1'b0;
        total++; if (state !== 2'd2 || pc_we !== 1'b0 || ifid_flush !== 1'b1 || ex_tag !== 7'd17 || id_valid !== 1'b0)
            begin bad++; $display("FAIL drain_entry state=%0d pc_we=%b flush=%b ex=%0d id_v=%b exp 2/0/1/17/0", state, pc_we, ifid_flush, ex_tag, id_valid); end
        tick();
        total++; if (if_valid !== 1'b0 || id_valid !== 1'b0 || state !== 2'd2 || retire_tag !== 7'd16)
            begin bad++; $display("FAIL drain_kill if_v=%b id_v=%b state=%0d wb=%0d exp 0/0/2/16", if_valid, id_valid, state, retire_tag); end
        tick();
        total++; if (retire !== 1'b1 || retire_tag !== 7'd17 || state !== 2'd2 || done !== 1'b0)
            begin bad++; $display("FAIL halt_retire retire=%b tag=%0d state=%0d done=%b exp 1/17/2/0", retire, retire_tag, state, done); end
        for (int c = 0; c < 3; c++) begin
            stall_req = 1'b1;
            tick();
            total++; if (done !== 1'b1 || state !== 2'd3 || retire !== 1'b0 || pc_we !== 1'b0 || idex_bubble !== 1'b0)
                begin bad++; $display("FAIL done_sticky c=%0d done=%b state=%0d retire=%b pc_we=%b bubble=%b exp 1/3/0/0/0", c, done, state, retire, pc_we, idex_bubble); end
        end
        stall_req = 1'b0;
`ifdef PIPE_PERF_CNT_EN
        total++; if (cyc_cnt !== 32'd26 || ret_cnt !== 32'd16 || stall_cnt !== 32'd3 || flush_cnt !== 32'd2)
            begin bad++; $display("FAIL perf cyc=%0d ret=%0d stall=%0d flush=%0d exp 26/16/3/2", cyc_cnt, ret_cnt, stall_cnt, flush_cnt); end
`else
        total++; if ({cyc_cnt, ret_cnt, stall_cnt, flush_cnt} !== '0)
            begin bad++; $display("FAIL perf_off cyc=%0d ret=%0d stall=%0d flush=%0d exp 0", cyc_cnt, ret_cnt, stall_cnt, flush_cnt); end
`endif
    endtask

    task automatic test_wrap;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 150; k++) begin
            tick();
            total++; if (if_tag !== TAG_W'(k % NUM_TAGS) || if_valid !== 1'b1)
                begin bad++; $display("FAIL wrap_fetch k=%0d got=%0d exp=%0d", k, if_tag, k % NUM_TAGS); end
            if (k >= 4) begin
                total++; if (retire !== 1'b1 || retire_tag !== TAG_W'((k - 4) % NUM_TAGS))
                    begin bad++; $display("FAIL wrap_retire k=%0d got=%0d/%b exp=%0d/1", k, retire_tag, retire, (k - 4) % NUM_TAGS); end
            end
        end
    endtask

    task automatic test_async_reset;
        rst_n = 1'b0;
        #1;
        total++; if (state !== 2'd0 || pc_we !== 1'b0 || ifid_we !== 1'b0 || {if_valid, id_valid, ex_valid, mem_valid, wb_valid, retire} !== 6'd0 || if_tag !== '0 || wb_tag !== '0)
            begin bad++; $display("FAIL async_reset state=%0d pc_we=%b valids=%b%b%b%b%b if=%0d exp all 0", state, pc_we, if_valid, id_valid, ex_valid, mem_valid, wb_valid, if_tag); end
        #10 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_flush();
        test_stall_flush();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
